// File: rtl/spi_device_model_if.sv
// Bundle of the SPI wires plus the local tx/rx user port of the SPI device model.
// The slave modport is the device view; the master modport is the controller/user view.
interface spi_device_model_if #(
    parameter int WIDTH = 32
);
    logic             spi_clk;
    logic             spi_cs;
    logic             spi_mosi;
    logic             spi_miso;
    logic             gpio_trigger;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_done;
    logic             tx_abort;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_err;

    modport slave (
        input  spi_clk, spi_cs, spi_mosi, tx_data, tx_valid,
        output spi_miso, gpio_trigger, tx_ready, tx_done, tx_abort,
               rx_data, rx_valid, rx_err
    );

    modport master (
        output spi_clk, spi_cs, spi_mosi, tx_data, tx_valid,
        input  spi_miso, gpio_trigger, tx_ready, tx_done, tx_abort,
               rx_data, rx_valid, rx_err
    );
endinterface

// File: rtl/spi_device_model.sv
// SPI device model: receives LSB-first words on mosi, requests a read with a
// low gpio pulse and then shifts its word out MSB-first on miso.
module spi_device_model #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TRIG_LEN    = 4
) (
    input  logic              clk,
    input  logic              rst,
    spi_device_model_if.slave bus
);
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int TRIG_W = $clog2(TRIG_LEN);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_LEN - 1);
    localparam logic [TRIG_W-1:0] TRIG_ONE  = TRIG_W'(1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_TRIG,
        TX_ARMED,
        TX_SHIFT
    } tx_state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   cs_hist_q, cs_hist_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_err_q, rx_err_d;

    tx_state_e         state_q, state_d;
    logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
    logic              miso_q, miso_d;
    logic              gpio_q, gpio_d;
    logic              tx_ready_q, tx_ready_d;
    logic              tx_done_q, tx_done_d;
    logic              tx_abort_q, tx_abort_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
        sclk_hist_d = sclk_s;
        cs_hist_d   = cs_s;
    end

    // The shifter holds only WIDTH-1 bits; the final mosi bit goes straight into rx_data.
    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        if (cs_fall) begin
            rx_cnt_d = '0;
        end else if (cs_rise) begin
            if (rx_cnt_q != '0 && rx_cnt_q != CNT_FULL) begin
                rx_err_d = 1'b1;
            end
            rx_cnt_d = '0;
        end else if (sclk_rise && !cs_s && rx_cnt_q != CNT_FULL) begin
            rx_shift_d = {mosi_s, rx_shift_q[WIDTH-2:1]};
            rx_cnt_d   = rx_cnt_q + CNT_ONE;
            if (rx_cnt_q == CNT_LAST) begin
                rx_data_d  = {mosi_s, rx_shift_q};
                rx_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        trig_cnt_d = trig_cnt_q;
        miso_d     = miso_q;
        tx_done_d  = 1'b0;
        tx_abort_d = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                miso_d = 1'b0;
                if (bus.tx_valid) begin
                    tx_shift_d = bus.tx_data;
                    trig_cnt_d = '0;
                    state_d    = TX_TRIG;
                end
            end
            TX_TRIG: begin
                miso_d = 1'b0;
                if (trig_cnt_q == TRIG_LAST) begin
                    state_d = TX_ARMED;
                end else begin
                    trig_cnt_d = trig_cnt_q + TRIG_ONE;
                end
            end
            TX_ARMED: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    miso_d   = tx_shift_q[WIDTH-1];
                    tx_cnt_d = '0;
                    state_d  = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                // Completion wins over a cs rise landing in the same cycle.
                if (sclk_rise && tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d  = CNT_FULL;
                    tx_done_d = 1'b1;
                    miso_d    = 1'b0;
                    state_d   = TX_IDLE;
                end else if (cs_rise) begin
                    tx_abort_d = 1'b1;
                    miso_d     = 1'b0;
                    state_d    = TX_IDLE;
                end else if (sclk_rise) begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end else if (sclk_fall && tx_cnt_q != CNT_FULL) begin
                    tx_shift_d = tx_shift_q << 1;
                    miso_d     = tx_shift_q[WIDTH-2];
                end
            end
            default: begin
                miso_d  = 1'b0;
                state_d = TX_IDLE;
            end
        endcase
        gpio_d     = (state_d != TX_TRIG);
        tx_ready_d = (state_d == TX_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
            rx_cnt_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            state_q     <= TX_IDLE;
            tx_shift_q  <= '0;
            tx_cnt_q    <= '0;
            trig_cnt_q  <= '0;
            miso_q      <= 1'b0;
            gpio_q      <= 1'b1;
            tx_ready_q  <= 1'b1;
            tx_done_q   <= 1'b0;
            tx_abort_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_hist_q <= sclk_hist_d;
            cs_hist_q   <= cs_hist_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            trig_cnt_q  <= trig_cnt_d;
            miso_q      <= miso_d;
            gpio_q      <= gpio_d;
            tx_ready_q  <= tx_ready_d;
            tx_done_q   <= tx_done_d;
            tx_abort_q  <= tx_abort_d;
        end
    end

    assign bus.spi_miso     = miso_q;
    assign bus.gpio_trigger = gpio_q;
    assign bus.tx_ready     = tx_ready_q;
    assign bus.tx_done      = tx_done_q;
    assign bus.tx_abort     = tx_abort_q;
    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_err       = rx_err_q;
endmodule

// File: tb/tb_spi_device_model.sv
// Bench for spi_device_model: plays the SPI controller and compares each frame
// against a word-level model of what the device should receive and send.
module tb_spi_device_model;
    localparam int HALF = 5;
    localparam int TRIG = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    int rx_valid_cnt = 0;
    int rx_err_cnt = 0;
    int tx_done_cnt = 0;
    int tx_abort_cnt = 0;
    int trig_low_cnt = 0;

    logic [31:0] ref_rx_data;

    spi_device_model_if #(.WIDTH(32)) bus ();

    spi_device_model #(
        .WIDTH(32),
        .SYNC_STAGES(2),
        .TRIG_LEN(TRIG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Pulse outputs are one clk wide, so a negedge sample sees each exactly once.
    always @(negedge clk) begin
        if (bus.rx_valid) rx_valid_cnt++;
        if (bus.rx_err) rx_err_cnt++;
        if (bus.tx_done) tx_done_cnt++;
        if (bus.tx_abort) tx_abort_cnt++;
        if (!bus.gpio_trigger) trig_low_cnt++;
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_miso"}, {31'b0, bus.spi_miso}, 32'd0);
        checkOutput({tag, "_gpio"}, {31'b0, bus.gpio_trigger}, 32'd1);
        checkOutput({tag, "_tx_ready"}, {31'b0, bus.tx_ready}, 32'd1);
        checkOutput({tag, "_tx_done"}, {31'b0, bus.tx_done}, 32'd0);
        checkOutput({tag, "_tx_abort"}, {31'b0, bus.tx_abort}, 32'd0);
        checkOutput({tag, "_rx_data"}, bus.rx_data, 32'd0);
        checkOutput({tag, "_rx_valid"}, {31'b0, bus.rx_valid}, 32'd0);
        checkOutput({tag, "_rx_err"}, {31'b0, bus.rx_err}, 32'd0);
    endtask

    // Requests a tx word; checks the ready drop and the trigger pulse length.
    task automatic applyStimulus(input string tag, input logic [31:0] word);
        int snap;
        snap = trig_low_cnt;
        bus.tx_data  = word;
        bus.tx_valid = 1'b1;
        waitClk(1);
        bus.tx_valid = 1'b0;
        checkOutput({tag, "_ready_drop"}, {31'b0, bus.tx_ready}, 32'd0);
        waitClk(TRIG + 4);
        checkOutput({tag, "_trig_len"}, trig_low_cnt - snap, TRIG);
        checkOutput({tag, "_trig_idle"}, {31'b0, bus.gpio_trigger}, 32'd1);
    endtask

    task automatic shiftBits(input int nbits, input logic [31:0] mosi_word, output logic [31:0] miso_word);
        miso_word = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = mosi_word[i];
            waitClk(HALF);
            miso_word = {miso_word[30:0], bus.spi_miso};
            bus.spi_clk = 1'b1;
            waitClk(HALF);
            bus.spi_clk = 1'b0;
        end
    endtask

    // One controller frame of nbits rising edges, checked against the word-level model.
    task automatic runFrame(input string tag, input int nbits, input logic [31:0] mosi_word,
                            input bit armed, input logic [31:0] tx_word);
        int s_rxv, s_rxe, s_done, s_abort;
        logic [31:0] miso_word, exp_miso;
        s_rxv   = rx_valid_cnt;
        s_rxe   = rx_err_cnt;
        s_done  = tx_done_cnt;
        s_abort = tx_abort_cnt;
        bus.spi_cs = 1'b0;
        waitClk(HALF);
        shiftBits(nbits, mosi_word, miso_word);
        waitClk(HALF);
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        waitClk(HALF + 2);

        if (nbits == 32) ref_rx_data = mosi_word;
        exp_miso = armed ? (tx_word >> (32 - nbits)) : 32'd0;

        checkOutput({tag, "_rx_data"}, bus.rx_data, ref_rx_data);
        checkOutput({tag, "_rx_valid_n"}, rx_valid_cnt - s_rxv, (nbits == 32) ? 1 : 0);
        checkOutput({tag, "_rx_err_n"}, rx_err_cnt - s_rxe, (nbits < 32) ? 1 : 0);
        checkOutput({tag, "_miso_word"}, miso_word, exp_miso);
        checkOutput({tag, "_tx_done_n"}, tx_done_cnt - s_done, (armed && nbits == 32) ? 1 : 0);
        checkOutput({tag, "_tx_abort_n"}, tx_abort_cnt - s_abort, (armed && nbits < 32) ? 1 : 0);
        checkOutput({tag, "_tx_ready"}, {31'b0, bus.tx_ready}, 32'd1);
        checkOutput({tag, "_miso_idle"}, {31'b0, bus.spi_miso}, 32'd0);
    endtask

    initial begin
        logic [31:0] scratch;
        logic [31:0] tx_word;
        logic [31:0] rx_word;
        int          nbits;
        bit          armed;

        bus.spi_clk  = 1'b0;
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        ref_rx_data  = '0;

        waitClk(3);
        checkResetValues("reset");
        rst = 1'b0;
        waitClk(4);

        $display("[TB] rx word");
        runFrame("rx_word", 32, 32'hA5C3_0F81, 1'b0, '0);

        $display("[TB] short frame");
        runFrame("short", 12, 32'h0000_0ABC, 1'b0, '0);

        $display("[TB] tx word with ignored second request");
        applyStimulus("tx_req", 32'hDEAD_BEEF);
        bus.tx_data  = 32'h1111_1111;
        bus.tx_valid = 1'b1;
        waitClk(2);
        bus.tx_valid = 1'b0;
        runFrame("tx_word", 32, $urandom, 1'b1, 32'hDEAD_BEEF);

        $display("[TB] abort then re-arm");
        applyStimulus("abort_req", 32'h1357_9BDF);
        runFrame("abort", 10, $urandom, 1'b1, 32'h1357_9BDF);
        applyStimulus("rearm_req", 32'h2468_ACE0);
        runFrame("rearm", 32, $urandom, 1'b1, 32'h2468_ACE0);

        $display("[TB] full duplex");
        applyStimulus("duplex_req", 32'h0000_FFFF);
        runFrame("duplex", 32, 32'h1234_5678, 1'b1, 32'h0000_FFFF);

        $display("[TB] reset mid shift");
        applyStimulus("rst_req", $urandom);
        bus.spi_cs = 1'b0;
        waitClk(HALF);
        shiftBits(16, $urandom, scratch);
        rst = 1'b1;
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        waitClk(2);
        checkResetValues("mid_reset");
        rst = 1'b0;
        ref_rx_data = '0;
        waitClk(6);
        runFrame("post_reset", 32, 32'hC0FF_EE01, 1'b0, '0);

        $display("[TB] randomized frames");
        for (int k = 0; k < 20; k++) begin
            tx_word = $urandom;
            rx_word = $urandom;
            armed   = $urandom_range(0, 1) == 1;
            nbits   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 31)) : 32;
            if (armed) applyStimulus($sformatf("rnd%0d_req", k), tx_word);
            runFrame($sformatf("rnd%0d", k), nbits, rx_word, armed, tx_word);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
